// File: rtl/concat_unpacker.sv
// ============================================================================
//  concat_unpacker
//  Splits one packed word {f0,...,fN-1} into fields on a valid/ready stream,
//  f0 first. Optional replication check is enabled by defining REP_CHECK_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module concat_unpacker #(
  parameter int FIELD_W    = 8,
  parameter int NUM_FIELDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_data,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last,
  output logic                          rep_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                          state, state_next;
  logic [FIELD_W*NUM_FIELDS-1:0]   hold, hold_next;
  logic [IDX_W-1:0]                idx, idx_next;
  logic                            load;
  logic                            out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      idx   <= idx_next;
    end
  end

  // A new word may load in the same cycle the last field leaves, so there is no bubble.
  always_comb begin
    out_valid  = (state == EMIT);
    out_last   = out_valid && (idx == LAST_IDX);
    out_fire   = out_valid && out_ready;
    in_ready   = (state == IDLE) || (out_fire && out_last);
    load       = in_valid && in_ready;
    state_next = state;
    hold_next  = hold;
    idx_next   = idx;
    if (load) begin
      hold_next  = in_data;
      idx_next   = '0;
      state_next = EMIT;
    end else if (out_fire) begin
      if (out_last) begin
        idx_next   = '0;
        state_next = IDLE;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (state == EMIT) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        if (idx == IDX_W'(k)) begin
          out_data = hold[FIELD_W*(NUM_FIELDS-k)-1 -: FIELD_W];
        end
      end
    end
  end

  assign out_index = idx;

`ifdef REP_CHECK_EN
  logic rep_mismatch;

  // Compare the incoming word directly so the flag is ready with the first field.
  always_comb begin
    rep_mismatch = 1'b0;
    for (int k = 1; k < NUM_FIELDS; k++) begin
      if (in_data[FIELD_W*(NUM_FIELDS-k)-1 -: FIELD_W] !=
          in_data[FIELD_W*NUM_FIELDS-1 -: FIELD_W]) begin
        rep_mismatch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_err <= 1'b0;
    end else if (load) begin
      rep_err <= rep_mismatch;
    end
  end
`else
  assign rep_err = 1'b0;
`endif

endmodule

`default_nettype wire
